// File: rtl/mult_wb_buffer.sv
// Result buffer between the mult unit and the shared writeback port.
// Fall-through FIFO: an empty buffer with a ready port bypasses the incoming result.
module mult_wb_buffer #(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned XLEN          = 64,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned STALL_SLACK   = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         in_valid_i,
  input  logic [TRANS_ID_BITS-1:0]     in_trans_id_i,
  input  logic [XLEN-1:0]              in_result_i,
  output logic                         wb_valid_o,
  output logic [TRANS_ID_BITS-1:0]     wb_trans_id_o,
  output logic [XLEN-1:0]              wb_result_o,
  input  logic                         wb_ready_i,
  output logic                         issue_stall_o,
  output logic [$clog2(DEPTH):0]       count_o,
  output logic                         overflow_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]            rd_ptr, wr_ptr;
  logic [XLEN-1:0]          res_mem [DEPTH];
  logic [TRANS_ID_BITS-1:0] id_mem  [DEPTH];

  logic          empty, full;
  logic          pop, push, deq, wr_en, drop;
  logic [CW-1:0] count_next;

  assign empty = (count_o == '0);
  assign full  = (count_o == CW'(DEPTH));

  always_comb begin
    if (empty) begin
      wb_valid_o    = in_valid_i;
      wb_trans_id_o = in_trans_id_i;
      wb_result_o   = in_result_i;
    end else begin
      wb_valid_o    = 1'b1;
      wb_trans_id_o = id_mem[rd_ptr];
      wb_result_o   = res_mem[rd_ptr];
    end
  end

  assign pop   = wb_valid_o & wb_ready_i & ~flush_i;
  assign push  = in_valid_i & ~flush_i & ~(empty & wb_ready_i);
  // A pop while empty is the bypass path: nothing leaves storage.
  assign deq   = pop & ~empty;
  assign wr_en = push & (~full | deq);
  assign drop  = push & full & ~deq;

  always_comb begin
    count_next = count_o;
    if (flush_i) count_next = '0;
    else         count_next = count_o + CW'(wr_en) - CW'(deq);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count_o       <= '0;
      issue_stall_o <= 1'b0;
      overflow_o    <= 1'b0;
    end else begin
      count_o       <= count_next;
      issue_stall_o <= (count_next > CW'(DEPTH - STALL_SLACK));
      if (drop) overflow_o <= 1'b1;
      if (flush_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (deq)   rd_ptr <= rd_ptr + 1'b1;
        if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      res_mem[wr_ptr] <= in_result_i;
      id_mem[wr_ptr]  <= in_trans_id_i;
    end
  end

endmodule
